// File: rtl/rv_multiport_ram_be_if.sv
// Bundle of request/response signals for the multiport byte-enable RAM.
// Latency: n/a (wiring only).
// Backpressure: none; every request presented while init_done=1 is accepted.
interface rv_multiport_ram_be_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RD     = 2
);
    logic                         init_done;
    logic [NUM_RD-1:0]            rd_en;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_addr;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]            rd_valid;
    logic                         b_en;
    logic                         b_we;
    logic [DATA_WIDTH/8-1:0]      b_be;
    logic [DATA_WIDTH-1:0]        b_addr;
    logic [DATA_WIDTH-1:0]        b_wdata;
    logic [DATA_WIDTH-1:0]        b_rdata;
    logic                         b_valid;

    // Requester side (fetch units / load-store unit)
    modport master (
        input  init_done, rd_data, rd_valid, b_rdata, b_valid,
        output rd_en, rd_addr, b_en, b_we, b_be, b_addr, b_wdata
    );

    // RAM side
    modport slave (
        output init_done, rd_data, rd_valid, b_rdata, b_valid,
        input  rd_en, rd_addr, b_en, b_we, b_be, b_addr, b_wdata
    );
endinterface

// File: rtl/rv_multiport_ram_be.sv
// NUM_RD read ports + one byte-enable RW port over one array, write-first forwarding, optional post-reset clear.
// Latency: 1 cycle for all reads; writes land on the request edge; init_done after 2**ADDR_WIDTH edges (1 if no clear).
// Backpressure: none; requests while init_done=0 are dropped, otherwise every request completes in one cycle.
module rv_multiport_ram_be #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_RD     = 2,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    rv_multiport_ram_be_if.slave bus
);
    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    localparam state_t RESET_STATE = INIT_CLEAR ? ST_CLEAR : ST_READY;

    // Storage is deliberately never reset; the clear sequencer handles zeroing.
    word_t mem [DEPTH];

    state_t                       state_q, state_d;
    addr_t                        cnt_q, cnt_d;
    logic                         init_done_q, init_done_d;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [NUM_RD-1:0]            rd_valid_q, rd_valid_d;
    word_t                        b_rdata_q, b_rdata_d;
    logic                         b_valid_q, b_valid_d;

    addr_t b_addr_w;
    word_t b_old;
    word_t b_merged;
    logic  b_wr;
    logic  wr_en;
    addr_t wr_addr;
    word_t wr_word;

    // Only the low ADDR_WIDTH address bits select a word; the rest alias away.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.rd_addr, bus.b_addr};

    // Write path: merged RW-port word, or a zero word while the clear sequencer runs.
    always_comb begin
        b_addr_w = bus.b_addr[ADDR_WIDTH-1:0];
        b_old    = mem[b_addr_w];
        b_wr     = init_done_q & bus.b_en & bus.b_we;
        b_merged = b_old;
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (bus.b_be[k]) begin
                b_merged[k*8 +: 8] = bus.b_wdata[k*8 +: 8];
            end
        end
        if (state_q == ST_CLEAR) begin
            wr_en   = rst_n;
            wr_addr = cnt_q;
            wr_word = '0;
        end else begin
            wr_en   = b_wr;
            wr_addr = b_addr_w;
            wr_word = b_merged;
        end
    end

    // Clear sequencer next state; init_done rises on the edge that clears the last word.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d     = ST_READY;
                    init_done_d = 1'b1;
                end
            end
            default: begin
                init_done_d = 1'b1;
            end
        endcase
    end

    // Read responses; a read hitting this edge's write address sees the merged word (write-first).
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = '0;
        b_rdata_d  = b_rdata_q;
        b_valid_d  = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (init_done_q && bus.rd_en[i]) begin
                rd_valid_d[i] = 1'b1;
                if (b_wr && (bus.rd_addr[i*DATA_WIDTH +: ADDR_WIDTH] == b_addr_w)) begin
                    rd_data_d[i*DATA_WIDTH +: DATA_WIDTH] = b_merged;
                end else begin
                    rd_data_d[i*DATA_WIDTH +: DATA_WIDTH] = mem[bus.rd_addr[i*DATA_WIDTH +: ADDR_WIDTH]];
                end
            end
        end
        if (init_done_q && bus.b_en && !bus.b_we) begin
            b_valid_d = 1'b1;
            b_rdata_d = b_old;
        end
    end

    // Control and response registers; reset aborts a clear in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RESET_STATE;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= '0;
            b_rdata_q   <= '0;
            b_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            b_rdata_q   <= b_rdata_d;
            b_valid_q   <= b_valid_d;
        end
    end

    // Array write port, shared by the clear sequencer and the RW port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_word;
        end
    end

    assign bus.init_done = init_done_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.b_rdata   = b_rdata_q;
    assign bus.b_valid   = b_valid_q;
endmodule

// File: tb/tb_rv_multiport_ram_be.sv
// Directed bench for rv_multiport_ram_be (ADDR_WIDTH=4, two read ports, clear enabled).
// Inputs change 1ns after a rising edge; outputs are sampled 1ns after the following edge.
// Each test task carries its own inline comparisons against hand-computed values.
module tb_rv_multiport_ram_be;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NR = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    rv_multiport_ram_be_if #(.DATA_WIDTH(DW), .NUM_RD(NR)) bus ();

    rv_multiport_ram_be #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .INIT_CLEAR(1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rd_en   = '0;
        bus.rd_addr = '0;
        bus.b_en    = 1'b0;
        bus.b_we    = 1'b0;
        bus.b_be    = '0;
        bus.b_addr  = '0;
        bus.b_wdata = '0;
    endtask

    task automatic set_rd(input int p, input logic [DW-1:0] addr);
        bus.rd_en[p]             = 1'b1;
        bus.rd_addr[p*DW +: DW]  = addr;
    endtask

    task automatic b_write(input logic [DW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] be);
        bus.b_en    = 1'b1;
        bus.b_we    = 1'b1;
        bus.b_addr  = addr;
        bus.b_wdata = data;
        bus.b_be    = be;
    endtask

    task automatic b_read(input logic [DW-1:0] addr);
        bus.b_en   = 1'b1;
        bus.b_we   = 1'b0;
        bus.b_addr = addr;
    endtask

    function automatic logic [DW-1:0] rdd(input int p);
        return bus.rd_data[p*DW +: DW];
    endfunction

    task automatic test_reset();
        logic [DW-1:0] got0, got1;
        logic exp_done;
        idle();
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if ({bus.init_done, bus.rd_valid, bus.b_valid} !== 4'b0000 || bus.rd_data !== '0 || bus.b_rdata !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: init_done=%b rd_valid=%b b_valid=%b rd_data=%h b_rdata=%h, required all zero",
                     bus.init_done, bus.rd_valid, bus.b_valid, bus.rd_data, bus.b_rdata);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            idle();
            if (e == 10) begin
                b_write(32'h3, 32'hFFFF_FFFF, 4'hF);
                set_rd(0, 32'h3);
            end
            tick();
            exp_done = (e == 16);
            n_cmp++;
            if (bus.init_done !== exp_done) begin
                n_err++;
                $display("FAIL init_done_edge%0d: got %b, required %b", e, bus.init_done, exp_done);
            end
            if (e == 10) begin
                n_cmp++;
                if (bus.rd_valid !== 2'b00) begin
                    n_err++;
                    $display("FAIL clear_read_ignored: rd_valid=%b, required 00", bus.rd_valid);
                end
            end
        end
        for (int a = 0; a < 16; a++) begin
            idle();
            set_rd(0, a);
            set_rd(1, 15 - a);
            tick();
            got0 = rdd(0);
            got1 = rdd(1);
            n_cmp++;
            if (got0 !== 32'h0 || got1 !== 32'h0 || bus.rd_valid !== 2'b11) begin
                n_err++;
                $display("FAIL cleared_word_%0d: p0=%h p1=%h valid=%b, required 0 0 11", a, got0, got1, bus.rd_valid);
            end
        end
    endtask

    task automatic test_byte_enable();
        idle();
        b_write(32'h5, 32'hAABB_CCDD, 4'hF);
        tick();
        idle();
        b_write(32'h5, 32'h1122_3344, 4'b0101);
        tick();
        n_cmp++;
        if (bus.b_valid !== 1'b0) begin
            n_err++;
            $display("FAIL write_no_bvalid: b_valid=%b, required 0", bus.b_valid);
        end
        idle();
        set_rd(0, 32'h5);
        tick();
        n_cmp++;
        if (rdd(0) !== 32'hAA22_CC44 || bus.rd_valid[0] !== 1'b1) begin
            n_err++;
            $display("FAIL byte_enable: data=%h valid=%b, required AA22CC44 1", rdd(0), bus.rd_valid[0]);
        end
        idle();
        tick();
        n_cmp++;
        if (bus.rd_valid !== 2'b00) begin
            n_err++;
            $display("FAIL rd_valid_strobe: rd_valid=%b, required 00", bus.rd_valid);
        end
    endtask

    task automatic test_raw_forward();
        idle();
        b_write(32'h7, 32'h1234_5678, 4'hF);
        tick();
        idle();
        b_write(32'h7, 32'hFFFF_FFFF, 4'b1000);
        set_rd(0, 32'h7);
        set_rd(1, 32'h7);
        tick();
        n_cmp++;
        if (rdd(0) !== 32'hFF34_5678 || rdd(1) !== 32'hFF34_5678 || bus.rd_valid !== 2'b11) begin
            n_err++;
            $display("FAIL raw_forward: p0=%h p1=%h valid=%b, required FF345678 FF345678 11", rdd(0), rdd(1), bus.rd_valid);
        end
        idle();
        b_read(32'h7);
        tick();
        n_cmp++;
        if (bus.b_rdata !== 32'hFF34_5678 || bus.b_valid !== 1'b1) begin
            n_err++;
            $display("FAIL raw_b_readback: b_rdata=%h b_valid=%b, required FF345678 1", bus.b_rdata, bus.b_valid);
        end
    endtask

    task automatic test_alias();
        idle();
        b_write(32'h13, 32'hDEAD_BEEF, 4'hF);
        tick();
        idle();
        set_rd(0, 32'h3);
        set_rd(1, 32'h23);
        tick();
        n_cmp++;
        if (rdd(0) !== 32'hDEAD_BEEF || rdd(1) !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL alias: p0=%h p1=%h, required DEADBEEF DEADBEEF", rdd(0), rdd(1));
        end
    endtask

    task automatic test_hold_strobe();
        idle();
        b_write(32'h9, 32'h5, 4'hF);
        tick();
        idle();
        set_rd(1, 32'h9);
        tick();
        n_cmp++;
        if (rdd(1) !== 32'h5 || bus.rd_valid !== 2'b10) begin
            n_err++;
            $display("FAIL hold_first_read: p1=%h valid=%b, required 5 10", rdd(1), bus.rd_valid);
        end
        for (int c = 0; c < 3; c++) begin
            idle();
            bus.rd_addr[DW +: DW] = 32'h5;
            tick();
            n_cmp++;
            if (rdd(1) !== 32'h5 || bus.rd_valid[1] !== 1'b0) begin
                n_err++;
                $display("FAIL hold_cycle%0d: p1=%h valid=%b, required 5 0", c, rdd(1), bus.rd_valid[1]);
            end
        end
        idle();
        bus.b_en    = 1'b0;
        bus.b_we    = 1'b1;
        bus.b_be    = 4'hF;
        bus.b_addr  = 32'h9;
        bus.b_wdata = 32'h77;
        tick();
        idle();
        b_read(32'h9);
        tick();
        n_cmp++;
        if (bus.b_rdata !== 32'h5 || bus.b_valid !== 1'b1) begin
            n_err++;
            $display("FAIL no_en_write: b_rdata=%h b_valid=%b, required 5 1", bus.b_rdata, bus.b_valid);
        end
        idle();
        tick();
        n_cmp++;
        if (bus.b_rdata !== 32'h5 || bus.b_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b_hold: b_rdata=%h b_valid=%b, required 5 0", bus.b_rdata, bus.b_valid);
        end
    endtask

    task automatic test_mid_reset();
        int waited;
        idle();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.init_done !== 1'b0 || bus.rd_data !== '0 || bus.b_rdata !== '0) begin
            n_err++;
            $display("FAIL async_reset: init_done=%b rd_data=%h b_rdata=%h, required 0 0 0", bus.init_done, bus.rd_data, bus.b_rdata);
        end
        tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.init_done !== 1'b0 || bus.rd_valid !== 2'b00 || bus.b_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midclear_reset: init_done=%b rd_valid=%b b_valid=%b, required 0 00 0", bus.init_done, bus.rd_valid, bus.b_valid);
        end
        tick();
        rst_n = 1'b1;
        waited = 0;
        while (bus.init_done !== 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        n_cmp++;
        if (waited !== 16) begin
            n_err++;
            $display("FAIL restart_clear_edges: got %0d edges, required 16", waited);
        end
        idle();
        set_rd(0, 32'h9);
        set_rd(1, 32'h7);
        tick();
        n_cmp++;
        if (rdd(0) !== 32'h0 || rdd(1) !== 32'h0 || bus.rd_valid !== 2'b11) begin
            n_err++;
            $display("FAIL recleared: p0=%h p1=%h valid=%b, required 0 0 11", rdd(0), rdd(1), bus.rd_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_byte_enable();
        test_raw_forward();
        test_alias();
        test_hold_strobe();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rv_multiport_ram_be.md
Name: rv_multiport_ram_be

Overview:
Parametrised successor to the single-read/single-RW instruction/data RAM. It provides NUM_RD read-only ports plus one read/write port with byte enables. Read-after-write forwarding makes reads of a same-cycle write address return the merged new word. An optional post-reset clear sequencer zeroes the array before the ports accept traffic. It sits between the multithreaded core's fetch units (read ports) and the load/store unit (RW port).

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8
ADDR_WIDTH, 10, word-address bits; depth = 2**ADDR_WIDTH words
NUM_RD, 2, number of read-only ports (1..4)
INIT_CLEAR, 1, 1 = zero all words after reset before init_done; 0 = no clear, contents undefined

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
init_done  out  1  high when the RAM accepts requests
rd_en  in  NUM_RD  per-port read request
rd_addr  in  NUM_RD*DATA_WIDTH  flattened word addresses; port i = bits [i*DATA_WIDTH +: DATA_WIDTH]
rd_data  out  NUM_RD*DATA_WIDTH  flattened read data
rd_valid  out  NUM_RD  per-port data-valid strobe
b_en  in  1  RW port request
b_we  in  1  1 = write, 0 = read (qualified by b_en)
b_be  in  DATA_WIDTH/8  byte enables for writes
b_addr  in  DATA_WIDTH  RW port word address
b_wdata  in  DATA_WIDTH  write data
b_rdata  out  DATA_WIDTH  RW port read data
b_valid  out  1  RW read-data-valid strobe

Behaviour:
- Reset (rst_n=0, async): init_done=0, rd_data=0, rd_valid=0, b_rdata=0, b_valid=0, FSM=CLEAR (INIT_CLEAR=1) or READY-pending (INIT_CLEAR=0), clear counter=0. Array contents are not reset.
- FSM states:
  - CLEAR: each edge writes 0 to mem[cnt] and increments cnt. On the edge that writes address 2**ADDR_WIDTH-1, go to READY.
  - READY: terminal state.
- init_done is registered. It goes high exactly 2**ADDR_WIDTH edges after rst_n deasserts (1024 by default), or 1 edge after when INIT_CLEAR=0.
- Requests while init_done=0 are ignored: no writes, valids stay 0.
- Reset asserted mid-CLEAR aborts it immediately. The clear restarts from address 0 after release.
- Addresses: only bits [ADDR_WIDTH-1:0] are used on all ports, for both read and write. Higher bits are ignored, so addresses alias.
- Read ports: latency 1. rd_en[i]=1 at edge N gives rd_data[i] and rd_valid[i]=1 after edge N. rd_valid[i] is a one-cycle strobe per request. rd_data[i] holds its last value when rd_en[i]=0.
- RW read (b_en=1, b_we=0): latency 1; b_rdata and b_valid behave like the read ports.
- RW write (b_en=1, b_we=1): on the edge, byte k of mem[addr] takes b_wdata byte k where b_be[k]=1; other bytes are unchanged. b_be=0 is a legal no-op. b_valid=0 and b_rdata holds its value.
- Forwarding: if read port i reads the same truncated address written that edge, rd_data[i] = old word with the enabled bytes replaced by b_wdata, i.e. write-first. This applies to all read ports simultaneously.
- Multiple read ports at the same address all return identical data.
- There are no stalls or backpressure; every accepted request completes in 1 cycle.

Test Plan:
- Reset clear: INIT_CLEAR=1, ADDR_WIDTH=4. Release rst_n → init_done rises on edge 16; reads of all 16 words return 0x00000000. A write at edge 10 is dropped, and a readback of that address returns 0.
- Byte-enable write: write 0xAABBCCDD to addr 5 with be=4'hF, then 0x11223344 with be=4'b0101 → port 0 read of addr 5 returns 0xAA22CC44 with rd_valid[0]=1 one cycle after rd_en.
- RAW forwarding: addr 7 holds 0x12345678. In the same cycle, write 0xFFFFFFFF be=4'b1000 to addr 7 and read addr 7 on ports 0 and 1 → both return 0xFF345678 next cycle. A subsequent b read also returns 0xFF345678.
- Aliasing: ADDR_WIDTH=4. Write 0xDEADBEEF to b_addr=0x13 → rd_addr=0x3 returns 0xDEADBEEF.
- Reset mid-clear: assert rst_n=0 at clear edge 8 → all outputs read 0 immediately. After release, init_done rises 16 edges later, not 8.
- Hold and strobe: a read returns 0x5 on port 1; then rd_en=0 for 3 cycles → rd_data stays 0x5 and rd_valid[1]=0 throughout. b_we=1 with b_en=0 → memory unchanged.
